// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell iterated over a
// WIDTH-bit operand pair, LSB first, one bit per clock. The result, carry-out
// and signed overflow are presented together with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-bit full adder cell: sum bit
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // One-bit full adder cell: carry out
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] r_sh_r;      // partial result; the newest bit joins at the top
  logic             c_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic             accept_s;
  logic             last_s;
  logic             cell_sum_s;
  logic             cell_carry_s;
  logic [WIDTH-1:0] r_nx_s;

  // Cell evaluation and control decodes for the current cycle
  always_comb begin
    cell_sum_s   = fa_sum(a_sh_r[0], b_sh_r[0], c_r);
    cell_carry_s = fa_carry(a_sh_r[0], b_sh_r[0], c_r);
    r_nx_s       = {cell_sum_s, r_sh_r};
    // A request is honoured in IDLE and in DONE (back-to-back), never in RUN
    accept_s     = start && (state_r != RUN);
    last_s       = (state_r == RUN) && (cnt_r == LAST_BIT);
  end

  // Next-state logic of the IDLE/RUN/DONE sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, datapath shift registers and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      r_sh_r  <= '0;
      c_r     <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == RUN);
      done_r  <= (state_nx_s == DONE);
      if (accept_s) begin
        a_sh_r <= a;
        b_sh_r <= sub ? ~b : b;
        c_r    <= sub ? 1'b1 : cin;
        cnt_r  <= '0;
      end else if (state_r == RUN) begin
        a_sh_r <= a_sh_r >> 1'b1;
        b_sh_r <= b_sh_r >> 1'b1;
        r_sh_r <= r_nx_s[WIDTH-1:1];
        c_r    <= cell_carry_s;
        cnt_r  <= cnt_r + CW'(1);
      end
      // On the MSB cycle c_r is the carry into the MSB, the cell carry is cout
      if (last_s) begin
        sum_r  <= r_nx_s;
        cout_r <= cell_carry_s;
        ovf_r  <= c_r ^ cell_carry_s;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 64-bit instance run against a
// cycle-level behavioural model computed with plain integer arithmetic.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        start64, sub64, cin64;
  logic [63:0] a64, b64;
  logic        busy64, done64, cout64, ovf64;
  logic [63:0] sum64;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .overflow(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .sub(sub64), .a(a64), .b(b64),
    .cin(cin64), .busy(busy64), .done(done64), .sum(sum64), .cout(cout64),
    .overflow(ovf64)
  );

  // ---------------- behavioural model (index 0: WIDTH=8, 1: WIDTH=64) -----
  int          wd[2] = '{8, 64};
  int          rem[2];           // RUN cycles still to go, 0 when not running
  logic [63:0] p_sum[2];
  logic        p_cout[2], p_ovf[2];
  logic        m_busy[2], m_done[2], m_cout[2], m_ovf[2];
  logic [63:0] m_sum[2];

  task automatic model_step(input int i, input logic st, input logic s,
                            input logic [63:0] ta, input logic [63:0] tb,
                            input logic c);
    logic [63:0] mask, bb, rs;
    logic [64:0] tot;
    int w;
    w = wd[i];
    if (!rst_n) begin
      rem[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      m_sum[i] = 64'd0; m_cout[i] = 1'b0; m_ovf[i] = 1'b0;
    end else begin
      m_done[i] = 1'b0;
      if (rem[i] > 0) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 0) begin
          m_done[i] = 1'b1;
          m_sum[i]  = p_sum[i];
          m_cout[i] = p_cout[i];
          m_ovf[i]  = p_ovf[i];
        end
      end else if (st) begin
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        bb   = s ? (~tb & mask) : (tb & mask);
        tot  = {1'b0, ta & mask} + {1'b0, bb} + 65'(s ? 1'b1 : c);
        rs   = tot[63:0] & mask;
        p_sum[i]  = rs;
        p_cout[i] = tot[w];
        p_ovf[i]  = (ta[w-1] == bb[w-1]) && (rs[w-1] != ta[w-1]);
        rem[i]    = w;
      end
      m_busy[i] = (rem[i] > 0);
    end
  endtask

  // Advance the model with the inputs sampled at each rising edge
  always @(posedge clk) begin
    model_step(0, start8, sub8, {56'd0, a8}, {56'd0, b8}, cin8);
    model_step(1, start64, sub64, a64, b64, cin64);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8",  {63'd0, busy8},  {63'd0, m_busy[0]});
      chk("done8",  {63'd0, done8},  {63'd0, m_done[0]});
      chk("sum8",   {56'd0, sum8},   m_sum[0]);
      chk("cout8",  {63'd0, cout8},  {63'd0, m_cout[0]});
      chk("ovf8",   {63'd0, ovf8},   {63'd0, m_ovf[0]});
      chk("busy64", {63'd0, busy64}, {63'd0, m_busy[1]});
      chk("done64", {63'd0, done64}, {63'd0, m_done[1]});
      chk("sum64",  sum64,           m_sum[1]);
      chk("cout64", {63'd0, cout64}, {63'd0, m_cout[1]});
      chk("ovf64",  {63'd0, ovf64},  {63'd0, m_ovf[1]});
    end
  end

  // ---------------- directed helpers with literal expectations ------------
  task automatic op8(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tc, input logic ts, input logic [7:0] es,
                     input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; n = 1;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_lat"},  64'(n), 64'd9);
    chk({nm, "_sum"},  {56'd0, sum8}, {56'd0, es});
    chk({nm, "_cout"}, {63'd0, cout8}, {63'd0, ec});
    chk({nm, "_ovf"},  {63'd0, ovf8}, {63'd0, eo});
  endtask

  task automatic op64(input string nm, input logic [63:0] ta, input logic [63:0] tb,
                      input logic tc, input logic ts, input logic [63:0] es,
                      input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a64 = ta; b64 = tb; cin64 = tc; sub64 = ts; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0; n = 1;
    while (!done64 && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_lat"},  64'(n), 64'd65);
    chk({nm, "_sum"},  sum64, es);
    chk({nm, "_cout"}, {63'd0, cout64}, {63'd0, ec});
    chk({nm, "_ovf"},  {63'd0, ovf64}, {63'd0, eo});
  endtask

  // Global time bound so the run always ends
  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main stimulus ------------------------------------------
  initial begin
    int n, ops, cyc;
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    start64 = 1'b0; sub64 = 1'b0; cin64 = 1'b0; a64 = 64'd0; b64 = 64'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_sum64", sum64, 64'd0);
    rst_n = 1'b1;

    // Basic add, signed overflow, subtract with borrow
    op8("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("05_minus_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("09_minus_03", 8'h09, 8'h03, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0);

    // Held start: operands changed mid-RUN, re-accepted in the DONE cycle
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; n = 1;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    chk("b2b_first_lat", 64'(n), 64'd9);
    chk("b2b_first_sum", {56'd0, sum8}, 64'h30);
    @(negedge clk);
    start8 = 1'b0; n = 1;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    chk("b2b_second_gap", 64'(n), 64'd9);
    chk("b2b_second_sum", {56'd0, sum8}, 64'hFF);

    // Reset on RUN cycle 4 aborts the operation
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, busy8}, 64'd0);
    chk("abort_sum",  {56'd0, sum8}, 64'd0);
    chk("abort_cout", {63'd0, cout8}, 64'd0);
    repeat (12) @(negedge clk);
    op8("after_abort", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    // 64-bit: previous result must hold through the whole RUN
    op64("w64_small", 64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0);
    @(negedge clk);
    a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd0; cin64 = 1'b1; sub64 = 1'b0;
    start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0; n = 1;
    while (!done64 && n < 100) begin
      chk("w64_hold_sum", sum64, 64'd3);
      @(negedge clk);
      n++;
    end
    chk("w64_ones_lat",  64'(n), 64'd65);
    chk("w64_ones_sum",  sum64, 64'd0);
    chk("w64_ones_cout", {63'd0, cout64}, 64'd1);
    chk("w64_ones_ovf",  {63'd0, ovf64}, 64'd0);
    op64("w64_min_minus1", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Random regression: inputs change every cycle, start mostly held high
    ops = 0; cyc = 0;
    while (ops < 1000 && cyc < 75000) begin
      @(negedge clk);
      cyc++;
      if (done64) ops++;
      a64 = {$urandom(), $urandom()};
      b64 = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) b64 = a64;
      if ($urandom_range(0, 15) == 0) a64 = 64'hFFFF_FFFF_FFFF_FFFF;
      cin64   = 1'($urandom_range(0, 1));
      sub64   = 1'($urandom_range(0, 1));
      start64 = ($urandom_range(0, 7) != 0);
    end
    chk("rand_ops_completed", 64'(ops), 64'd1000);
    start64 = 1'b0;
    repeat (70) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
